neuron_mac_seq: RTL



---
 rtl/neuron_pkg.sv | 18 +
 rtl/neuron_act.sv | 33 +++
 rtl/neuron_mac_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared types and constants for the time-multiplexed neuron family.
package neuron_pkg;

  typedef enum logic [1:0] {
    ACT_LIN   = 2'b00,
    ACT_RELU  = 2'b01,
    ACT_LEAKY = 2'b10,
    ACT_RSVD  = 2'b11
  } act_mode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MAC  = 1'b1
  } state_t;

  localparam int unsigned LEAKY_SHIFT = 3;

endpackage

// File: rtl/neuron_act.sv
// Combinational clamp of a wide accumulator to signal width, then activation.
module neuron_act
  import neuron_pkg::*;
#(
  parameter int ACC_SIZE = 24,
  parameter int SIG_SIZE = 16
) (
  input  logic signed [ACC_SIZE-1:0] acc,
  input  act_mode_t                  mode,
  output logic signed [SIG_SIZE-1:0] result
);

  logic                       ovf;
  logic signed [SIG_SIZE-1:0] clamped;

  always_comb begin
    // Overflow when the bits above the signal's sign bit are not pure sign extension
    ovf = (acc[ACC_SIZE-1:SIG_SIZE-1] != {(ACC_SIZE-SIG_SIZE+1){acc[ACC_SIZE-1]}});
    if (ovf)
      clamped = acc[ACC_SIZE-1] ? {1'b1, {(SIG_SIZE-1){1'b0}}}
                                : {1'b0, {(SIG_SIZE-1){1'b1}}};
    else
      clamped = acc[SIG_SIZE-1:0];

    result = clamped;
    case (mode)
      ACT_RELU:  if (clamped[SIG_SIZE-1]) result = '0;
      ACT_LEAKY: if (clamped[SIG_SIZE-1]) result = clamped >>> LEAKY_SHIFT;
      default:   result = clamped;
    endcase
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed Q1.15 neuron: bias + sum(x[i]*W[i]) over NUM_INPUTS cycles,
// saturating accumulator, selectable activation. State updates on the falling edge.
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int SIG_SIZE    = 16,
  parameter int WEIGHT_SIZE = 16,
  parameter int FRAC_BITS   = 15,
  parameter int NUM_INPUTS  = 3,
  parameter int ACC_SIZE    = 24
) (
  input  logic                            CLOCK_N,
  input  logic                            RESET_N,
  input  logic [SIG_SIZE*NUM_INPUTS-1:0]  NEURON_IN,
  input  logic                            IN_VALID,
  output logic                            IN_READY,
  input  logic [1:0]                      ACT_MODE,
  input  logic                            WB_EN,
  input  logic [$clog2(NUM_INPUTS+1)-1:0] WB_ADDR,
  input  logic [WEIGHT_SIZE-1:0]          WB_DATA,
  output logic                            OUT_VALID,
  output logic [SIG_SIZE-1:0]             NEURON_OUT
);

  localparam int ADDR_W = $clog2(NUM_INPUTS+1);
  localparam int PROD_W = SIG_SIZE + WEIGHT_SIZE;
  localparam int SUM_W  = ((ACC_SIZE > PROD_W) ? ACC_SIZE : PROD_W) + 1;

  if (ACC_SIZE < SIG_SIZE + $clog2(NUM_INPUTS+1) + 1) begin : g_acc_too_narrow
    $error("neuron_mac_seq: ACC_SIZE too small for SIG_SIZE/NUM_INPUTS");
  end

  state_t                        state, state_nxt;
  act_mode_t                     mode_q;
  logic signed [SIG_SIZE-1:0]    x_q [NUM_INPUTS];
  logic signed [WEIGHT_SIZE-1:0] w_q [NUM_INPUTS];
  logic signed [WEIGHT_SIZE-1:0] bias_q, bias_eff;
  logic signed [ACC_SIZE-1:0]    acc_q, acc_nxt;
  logic [ADDR_W-1:0]             idx_q;
  logic                          accept, last, wb_ok, wb_bias, sum_ovf;
  logic signed [PROD_W-1:0]      prod, prod_sh;
  logic signed [SUM_W-1:0]       sum;
  logic signed [SIG_SIZE-1:0]    act_out;
  logic [SIG_SIZE-1:0]           out_q;
  logic                          valid_q;

  always_ff @(negedge CLOCK_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (IN_VALID) state_nxt = S_MAC;
      S_MAC:   if (last)     state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept   = (state == S_IDLE) && IN_VALID;
    last     = (state == S_MAC) && (idx_q == ADDR_W'(NUM_INPUTS-1));
    wb_ok    = WB_EN && (state == S_IDLE);
    wb_bias  = wb_ok && (WB_ADDR == ADDR_W'(NUM_INPUTS));
    // A bias write on the acceptance edge must already seed the accumulator
    bias_eff = wb_bias ? signed'(WB_DATA) : bias_q;

    prod    = x_q[idx_q] * w_q[idx_q];
    prod_sh = prod >>> FRAC_BITS;
    sum     = SUM_W'(acc_q) + SUM_W'(prod_sh);
    sum_ovf = (sum[SUM_W-1:ACC_SIZE-1] != {(SUM_W-ACC_SIZE+1){sum[SUM_W-1]}});
    if (sum_ovf)
      acc_nxt = sum[SUM_W-1] ? {1'b1, {(ACC_SIZE-1){1'b0}}}
                             : {1'b0, {(ACC_SIZE-1){1'b1}}};
    else
      acc_nxt = sum[ACC_SIZE-1:0];
  end

  // The final product and the activation land on the same edge
  neuron_act #(
    .ACC_SIZE (ACC_SIZE),
    .SIG_SIZE (SIG_SIZE)
  ) u_act (
    .acc    (acc_nxt),
    .mode   (mode_q),
    .result (act_out)
  );

  always_ff @(negedge CLOCK_N) begin
    if (!RESET_N) begin
      acc_q   <= '0;
      idx_q   <= '0;
      bias_q  <= '0;
      mode_q  <= ACT_LIN;
      out_q   <= '0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
    end else begin
      valid_q <= last;
      if (wb_bias)
        bias_q <= WB_DATA;
      else if (wb_ok && (WB_ADDR < ADDR_W'(NUM_INPUTS)))
        w_q[WB_ADDR] <= WB_DATA;

      if (accept) begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++)
          x_q[i] <= NEURON_IN[i*SIG_SIZE +: SIG_SIZE];
        mode_q <= act_mode_t'(ACT_MODE);
        acc_q  <= ACC_SIZE'(bias_eff);
        idx_q  <= '0;
      end else if (state == S_MAC) begin
        acc_q <= acc_nxt;
        if (last) begin
          idx_q <= '0;
          out_q <= act_out;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign IN_READY   = (state == S_IDLE);
  assign OUT_VALID  = valid_q;
  assign NEURON_OUT = out_q;

endmodule
